// File: rtl/exc_pkg.sv
// Shared exception-controller types and cause codes.
// EStatus encodings are common with maindec.
package exc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        VECT,
        HANDLER,
        RET,
        FAULT
    } exc_state_t;

    localparam logic [3:0] EXC_NONE = 4'b0000;
    localparam logic [3:0] EXC_IRQ  = 4'b0001;

endpackage

// File: rtl/exc_regs.sv
// ELR/ESR capture registers for exception entry.
// Load enables come from the exception FSM.
module exc_regs
    import exc_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         elr_load,
    input  logic         esr_load,
    input  logic [N-1:0] pc_d,
    input  logic [3:0]   esr_d,
    output logic [N-1:0] elr,
    output logic [3:0]   esr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            elr <= '0;
            esr <= EXC_NONE;
        end else begin
            if (elr_load) begin
                elr <= pc_d;
            end
            if (esr_load) begin
                esr <= esr_d;
            end
        end
    end

endmodule

// File: rtl/exception_controller.sv
// Exception entry/return sequencer for the LEGv8 single-cycle core.
// Drives PC freeze, vector/ELR redirect and IRQ acknowledge.
module exception_controller
    import exc_pkg::*;
#(
    parameter int           N      = 64,
    parameter logic [N-1:0] VECTOR = 64'hD8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   EStatus,
    input  logic         ERet,
    input  logic         ExtIRQ,
    input  logic [N-1:0] pc_in,
    output logic         Stall,
    output logic         ExcSel,
    output logic         ERetSel,
    output logic         ExtAck,
    output logic [N-1:0] ELR,
    output logic [3:0]   ESR,
    output logic         InHandler,
    output logic         Halt
);

    exc_state_t state_q;
    exc_state_t state_d;

    logic       sync_exc;
    logic       detect;
    logic       elr_load;
    logic       esr_load;
    logic [3:0] esr_d;

    // The handler vector must be a legal instruction address.
    always_comb begin
        assert (VECTOR[1:0] == 2'b00);
    end

    assign sync_exc = (EStatus != EXC_NONE);
    // Gated by reset so Stall stays low while reset is held.
    assign detect   = reset & (sync_exc | ExtIRQ);
    assign esr_d    = sync_exc ? EStatus : EXC_IRQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        elr_load = 1'b0;
        esr_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (detect) begin
                    state_d  = SAVE;
                    elr_load = 1'b1;
                    esr_load = 1'b1;
                end
            end
            SAVE:    state_d = VECT;
            VECT:    state_d = HANDLER;
            HANDLER: begin
                if (sync_exc) begin
                    state_d  = FAULT;
                    esr_load = 1'b1;
                end else if (ERet) begin
                    state_d = RET;
                end
            end
            RET:     state_d = IDLE;
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    exc_regs #(
        .N(N)
    ) u_regs (
        .clk      (clk),
        .reset    (reset),
        .elr_load (elr_load),
        .esr_load (esr_load),
        .pc_d     (pc_in),
        .esr_d    (esr_d),
        .elr      (ELR),
        .esr      (ESR)
    );

    assign Stall     = ((state_q == IDLE) & detect)
                     | (state_q == SAVE)
                     | (state_q == FAULT);
    assign ExcSel    = (state_q == VECT);
    assign ExtAck    = (state_q == VECT) & (ESR == EXC_IRQ);
    assign ERetSel   = (state_q == RET);
    assign InHandler = (state_q == HANDLER) | (state_q == RET);
    assign Halt      = (state_q == FAULT);

endmodule

// File: tb/tb_exception_controller.sv
// Randomized bench for exception_controller with a cycle-age
// reference model plus directed literal checks.
module tb_exception_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  EStatus = '0;
    logic        ERet = 1'b0;
    logic        ExtIRQ = 1'b0;
    logic [63:0] pc_in = '0;
    logic        Stall, ExcSel, ERetSel, ExtAck, InHandler, Halt;
    logic [63:0] ELR;
    logic [3:0]  ESR;

    int total = 0;
    int bad = 0;
    int ack_cnt = 0;

    exception_controller dut (
        .clk       (clk),
        .reset     (reset),
        .EStatus   (EStatus),
        .ERet      (ERet),
        .ExtIRQ    (ExtIRQ),
        .pc_in     (pc_in),
        .Stall     (Stall),
        .ExcSel    (ExcSel),
        .ERetSel   (ERetSel),
        .ExtAck    (ExtAck),
        .ELR       (ELR),
        .ESR       (ESR),
        .InHandler (InHandler),
        .Halt      (Halt)
    );

    always #5 clk = ~clk;

    // Model: age = cycles since entry (0 = not in an exception),
    // returning = one-cycle return redirect, halted = double fault.
    int          age;
    bit          returning;
    bit          halted;
    logic [63:0] m_elr;
    logic [3:0]  m_esr;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            age <= 0;
            returning <= 1'b0;
            halted <= 1'b0;
            m_elr <= '0;
            m_esr <= '0;
        end else if (halted) begin
            halted <= 1'b1;
        end else if (returning) begin
            returning <= 1'b0;
            age <= 0;
        end else if (age == 0) begin
            if (EStatus != 0 || ExtIRQ) begin
                age <= 1;
                m_elr <= pc_in;
                m_esr <= (EStatus != 0) ? EStatus : 4'd1;
            end
        end else if (age < 3) begin
            age <= age + 1;
        end else if (EStatus != 0) begin
            halted <= 1'b1;
            m_esr <= EStatus;
        end else if (ERet) begin
            returning <= 1'b1;
        end
    end

    function automatic logic [73:0] expected();
        logic st, ex, er, ak, ih, ht;
        st = 0; ex = 0; er = 0; ak = 0; ih = 0; ht = 0;
        if (halted) begin
            st = 1; ht = 1;
        end else if (returning) begin
            er = 1; ih = 1;
        end else if (age == 0) begin
            st = reset && (EStatus != 0 || ExtIRQ);
        end else if (age == 1) begin
            st = 1;
        end else if (age == 2) begin
            ex = 1; ak = (m_esr == 4'd1);
        end else begin
            ih = 1;
        end
        return {st, ex, er, ak, ih, ht, m_esr, m_elr};
    endfunction

    always @(negedge clk) begin
        logic [73:0] act, exp_v;
        act = {Stall, ExcSel, ERetSel, ExtAck, InHandler, Halt, ESR, ELR};
        exp_v = expected();
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL model t=%0t got=%h want=%h", $time, act, exp_v);
        end
        if (ExtAck) ack_cnt++;
        if ((ExcSel && ERetSel) || (Halt && (ExcSel || ERetSel || ExtAck))) begin
            bad++;
            $display("FAIL exclusive t=%0t sel=%b ret=%b ack=%b halt=%b",
                     $time, ExcSel, ERetSel, ExtAck, Halt);
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        EStatus = '0;
        ERet = 1'b0;
    endtask

    initial begin
        int acks0;
        // 1: reset held with toggling inputs
        for (int i = 0; i < 6; i++) begin
            EStatus = 4'($urandom);
            ERet = 1'($urandom);
            ExtIRQ = 1'($urandom);
            pc_in = {$urandom, $urandom};
            step();
            chk("rst_out", {58'd0, Stall, ExcSel, ERetSel, ExtAck, InHandler, Halt}, 64'd0);
            chk("rst_regs", ELR | 64'(ESR), 64'd0);
        end
        idle_in();
        ExtIRQ = 1'b0;
        reset = 1'b1;
        step();

        // 2: sync exception
        EStatus = 4'b0010;
        pc_in = 64'h40;
        #1 chk("detect_stall", 64'(Stall), 64'd1);
        step();
        idle_in();
        chk("save_stall", 64'(Stall), 64'd1);
        chk("sync_elr", ELR, 64'h40);
        chk("sync_esr", 64'(ESR), 64'h2);
        step();
        chk("vect_sel", 64'(ExcSel), 64'd1);
        chk("sync_noack", 64'(ExtAck), 64'd0);
        step();
        chk("in_handler", 64'(InHandler), 64'd1);
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        step();

        // 3: IRQ and return
        ExtIRQ = 1'b1;
        pc_in = 64'h80;
        step();
        pc_in = 64'h1000;
        step();
        chk("irq_ack", 64'(ExtAck), 64'd1);
        chk("irq_esr", 64'(ESR), 64'h1);
        ExtIRQ = 1'b0;
        step();
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        chk("ret_sel", 64'(ERetSel), 64'd1);
        step();
        chk("ret_one", 64'(ERetSel), 64'd0);
        chk("ret_idle", 64'(InHandler), 64'd0);
        chk("ret_elr", ELR, 64'h80);

        // 4: priority and masking
        EStatus = 4'b0100;
        ExtIRQ = 1'b1;
        pc_in = 64'hC0;
        step();
        EStatus = '0;
        chk("prio_esr", 64'(ESR), 64'h4);
        step();
        chk("prio_noack", 64'(ExtAck), 64'd0);
        for (int i = 0; i < 3; i++) step();
        chk("masked", 64'(InHandler), 64'd1);
        pc_in = 64'hC4;
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        step();
        chk("pend_taken", 64'(Stall), 64'd1);
        step();
        chk("pend_esr", 64'(ESR), 64'h1);
        step();
        chk("pend_ack", 64'(ExtAck), 64'd1);
        ExtIRQ = 1'b0;
        step();

        // 5: double fault
        EStatus = 4'b0010;
        ERet = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            EStatus = 4'($urandom);
            ERet = 1'($urandom);
            ExtIRQ = 1'($urandom);
            step();
            chk("halt", 64'({Halt, Stall}), 64'd3);
            chk("fault_elr", ELR, 64'hC4);
        end
        idle_in();
        ExtIRQ = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;

        // 6: reset mid-sequence
        ExtIRQ = 1'b1;
        pc_in = 64'h100;
        step();
        #2 reset = 1'b0;
        #1 chk("mid_rst", {Stall, ExcSel, ERetSel, ExtAck, InHandler, Halt, ESR, ELR}, 64'd0);
        acks0 = ack_cnt;
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (ExtAck) ExtIRQ = 1'b0;
        end
        chk("one_ack", 64'(ack_cnt - acks0), 64'd1);
        chk("fresh_elr", ELR, 64'h100);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            EStatus = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            ERet = ($urandom_range(0, 3) == 0);
            pc_in = {$urandom, $urandom} & ~64'h3;
            if (ExtAck) ExtIRQ = 1'b0;
            else if (!ExtIRQ && $urandom_range(0, 7) == 0) ExtIRQ = 1'b1;
            if (Halt && $urandom_range(0, 3) == 0) begin
                #2 reset = 1'b0;
                step();
                reset = 1'b1;
            end else if ($urandom_range(0, 59) == 0) begin
                reset = 1'b0;
                step();
                reset = 1'b1;
            end else begin
                step();
            end
        end

        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
